// File: rtl/median_seq.sv
// Sequential 3x3 median: loads nine samples into a MED element, partially bubble-sorts them and pulses DSO with the median.
// Optional macro MEDIAN_SEQ_ERR_EN adds a sticky ERR output flagging windows aborted during LOAD.

module med #(
    parameter int NUMBER = 9,
    parameter int WIDTH  = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    input  logic             BYP,
    output logic [WIDTH-1:0] DO
);
    localparam int PW = $clog2(NUMBER);

    logic [WIDTH-1:0] data_r [NUMBER];
    logic [WIDTH-1:0] data_s [NUMBER];
    logic [PW-1:0]    ptr_r;

    // Next data: shift on DSI, compare-exchange at ptr on BYP=0, otherwise hold.
    always_comb begin
        data_s = data_r;
        if (DSI) begin
            data_s[0] = DI;
            for (int i = 1; i < NUMBER; i++) begin
                data_s[i] = data_r[i-1];
            end
        end else if (!BYP) begin
            for (int i = 0; i < NUMBER - 1; i++) begin
                if ((ptr_r == PW'(i)) && (data_r[i] > data_r[i+1])) begin
                    data_s[i]   = data_r[i+1];
                    data_s[i+1] = data_r[i];
                end else begin
                end
            end
        end else begin
            data_s = data_r;
        end
    end

    // Data registers carry no reset; contents are meaningless until a full sort.
    always_ff @(posedge CLK) begin
        data_r <= data_s;
    end

    // Bubble position: restarts on every shift or bypass, advances on each compare.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr_r <= '0;
        end else if (DSI || BYP) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_r + PW'(1);
        end
    end

    // After five passes the five largest sit sorted at the top; the fifth largest is the median.
    assign DO = data_r[NUMBER/2];
endmodule

module median_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    output logic [WIDTH-1:0] DO,
    output logic             DSO,
    output logic             BUSY
`ifdef MEDIAN_SEQ_ERR_EN
    ,
    output logic             ERR
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SORT = 2'd2, DONE = 2'd3} state_t;

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic [2:0] pass_r, pass_s;
    logic       med_dsi_s, med_byp_s, abort_s;
    logic       dso_r, busy_r, err_r;

    med #(.NUMBER(9), .WIDTH(WIDTH)) u_med (
        .CLK  (CLK),
        .nRST (nRST),
        .DI   (DI),
        .DSI  (med_dsi_s),
        .BYP  (med_byp_s),
        .DO   (DO)
    );

    // Next-state, counters and MED control.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pass_s    = pass_r;
        med_dsi_s = 1'b0;
        med_byp_s = 1'b1;
        abort_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (DSI) begin
                    med_dsi_s = 1'b1;
                    cnt_s     = 4'd1;
                    state_s   = LOAD;
                end else begin
                    cnt_s = 4'd0;
                end
            end
            LOAD: begin
                if (DSI) begin
                    med_dsi_s = 1'b1;
                    if (cnt_r == 4'd8) begin
                        cnt_s   = 4'd0;
                        pass_s  = 3'd0;
                        state_s = SORT;
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end else begin
                    abort_s = 1'b1;
                    cnt_s   = 4'd0;
                    state_s = IDLE;
                end
            end
            SORT: begin
                // Pass p: (8-p) compare cycles, then (p+1) bypass cycles.
                med_byp_s = (cnt_r >= (4'd8 - {1'b0, pass_r}));
                if (cnt_r == 4'd8) begin
                    cnt_s = 4'd0;
                    if (pass_r == 3'd4) begin
                        pass_s  = 3'd0;
                        state_s = DONE;
                    end else begin
                        pass_s = pass_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
                pass_s  = 3'd0;
            end
        endcase
    end

    // State, counters and registered status flags.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            pass_r  <= 3'd0;
            dso_r   <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pass_r  <= pass_s;
            dso_r   <= (state_s == DONE);
            busy_r  <= (state_s == LOAD) || (state_s == SORT);
            err_r   <= err_r | abort_s;
        end
    end

    assign DSO  = dso_r;
    // BUSY also covers the cycle in which sample 1 is accepted.
    assign BUSY = nRST & (busy_r | ((state_r == IDLE) & DSI));

`ifdef MEDIAN_SEQ_ERR_EN
    assign ERR = err_r;
`endif
endmodule

// File: tb/tb_median_seq.sv
// Self-checking bench for median_seq: directed windows plus random windows against a sort-based median model.
module tb_median_seq;
    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [WIDTH-1:0] DI;
    logic             DSI;
    logic [WIDTH-1:0] DO;
    logic             DSO;
    logic             BUSY;
`ifdef MEDIAN_SEQ_ERR_EN
    logic             ERR;
`endif

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;

    always #5 CLK = ~CLK;

    median_seq #(.WIDTH(WIDTH)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .DI   (DI),
        .DSI  (DSI),
        .DO   (DO),
        .DSO  (DSO),
        .BUSY (BUSY)
`ifdef MEDIAN_SEQ_ERR_EN
        ,
        .ERR  (ERR)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample BUSY for the current cycle, then advance past the edge.
    task automatic tick();
        #1;
        if (BUSY === 1'b1) busy_cnt++;
        @(posedge CLK);
        #1;
    endtask

    function automatic int median9(input int v[9]);
        int q[$];
        foreach (v[i]) q.push_back(v[i]);
        q.sort();
        return q[4];
    endfunction

    task automatic load(input int v[9], input int nsamp);
        for (int i = 0; i < nsamp; i++) begin
            DI  = WIDTH'(v[i]);
            DSI = 1'b1;
            tick();
        end
        DSI = 1'b0;
    endtask

    task automatic wait_dso(input bit hold, output int n);
        n   = 0;
        DSI = hold;
        while (DSO !== 1'b1 && n < 100) begin
            if (hold) DI = WIDTH'($urandom);
            tick();
            n++;
        end
        DSI = 1'b0;
    endtask

    task automatic window(input string tag, input int v[9], input bit hold);
        int n;
        int m;
        m        = median9(v);
        busy_cnt = 0;
        load(v, 9);
        wait_dso(hold, n);
        check({tag, " latency"}, n, 45);
        check({tag, " median"}, DO, m);
        check({tag, " busy_cycles"}, busy_cnt, 54);
        tick();
        check({tag, " dso_pulse"}, DSO, 1'b0);
        check({tag, " do_hold"}, DO, m);
        check({tag, " busy_idle"}, BUSY, 1'b0);
    endtask

    initial begin
        int v[9];
        int n;

        nRST = 1'b0;
        DSI  = 1'b0;
        DI   = '0;
        #12;
        check("reset_busy", BUSY, 1'b0);
        check("reset_dso", DSO, 1'b0);
`ifdef MEDIAN_SEQ_ERR_EN
        check("reset_err", ERR, 1'b0);
`endif
        nRST = 1'b1;
        tick();

        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        window("ascending", v, 1'b0);
        v = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        window("descending", v, 1'b0);
        v = '{0, 255, 0, 255, 0, 255, 0, 255, 0};
        window("alternating", v, 1'b0);
        v = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        window("all_max", v, 1'b0);

        for (int w = 0; w < 5; w++) begin
            foreach (v[i]) v[i] = int'($urandom_range(0, 255));
            window($sformatf("random%0d", w), v, 1'b0);
        end

        // Strobe held through SORT and DONE must not disturb the window.
        foreach (v[i]) v[i] = int'($urandom_range(0, 255));
        window("dsi_hold", v, 1'b1);

        // Abort after four samples.
        v = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        load(v, 4);
        tick();
        check("abort_busy", BUSY, 1'b0);
        wait_dso(1'b0, n);
        check("abort_no_dso", n, 100);
`ifdef MEDIAN_SEQ_ERR_EN
        check("abort_err_sticky", ERR, 1'b1);
`endif

        // Reset in the middle of pass 2.
        v = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
        load(v, 9);
        repeat (21) tick();
        check("sort_busy", BUSY, 1'b1);
        nRST = 1'b0;
        #1;
        check("rst_busy", BUSY, 1'b0);
        check("rst_dso", DSO, 1'b0);
`ifdef MEDIAN_SEQ_ERR_EN
        check("rst_err_clear", ERR, 1'b0);
`endif
        tick();
        nRST = 1'b1;
        tick();
        wait_dso(1'b0, n);
        check("rst_no_dso", n, 100);
        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        window("after_reset", v, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
